// File: rtl/axil_mem_tester_pkg.sv
// axil_mem_tester_pkg: shared state encoding and constants for the AXI-lite memory tester
package axil_mem_tester_pkg;
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;
  localparam logic [1:0]  AXIL_RESP_OKAY    = 2'b00;
  localparam logic [31:0] LFSR_POLY         = 32'h8020_0003;
  localparam logic [31:0] LFSR_DEFAULT_SEED = 32'h0000_0001;
endpackage

// File: rtl/axil_lfsr32.sv
// axil_lfsr32: 32-bit Galois LFSR (x^32+x^22+x^2+x+1); a zero seed is replaced to avoid lock-up
module axil_lfsr32
  import axil_mem_tester_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] state
);
  always_ff @(posedge clk)
    if (!rst_n) state <= LFSR_DEFAULT_SEED;
    else if (load) state <= (seed == '0) ? LFSR_DEFAULT_SEED : seed;
    else if (advance) state <= (state >> 1) ^ (state[0] ? LFSR_POLY : '0);
endmodule

// File: rtl/axil_mem_tester.sv
// axil_mem_tester: AXI-lite master BIST; writes an LFSR pattern over NUM_WORDS words, reads back and compares
module axil_mem_tester
  import axil_mem_tester_pkg::*;
#(
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DATA_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int                    NUM_WORDS     = 1024,
  parameter int                    ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [31:0]              seed,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [ADDR_WIDTH-1:0]    first_err_addr,
  output logic [ADDR_WIDTH-1:0]    m_axil_awaddr,
  output logic [2:0]               m_axil_awprot,
  output logic                     m_axil_awvalid,
  input  logic                     m_axil_awready,
  output logic [DATA_WIDTH-1:0]    m_axil_wdata,
  output logic [DATA_WIDTH/8-1:0]  m_axil_wstrb,
  output logic                     m_axil_wvalid,
  input  logic                     m_axil_wready,
  input  logic [1:0]               m_axil_bresp,
  input  logic                     m_axil_bvalid,
  output logic                     m_axil_bready,
  output logic [ADDR_WIDTH-1:0]    m_axil_araddr,
  output logic [2:0]               m_axil_arprot,
  output logic                     m_axil_arvalid,
  input  logic                     m_axil_arready,
  input  logic [DATA_WIDTH-1:0]    m_axil_rdata,
  input  logic [1:0]               m_axil_rresp,
  input  logic                     m_axil_rvalid,
  output logic                     m_axil_rready
);
  localparam int IW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
  state_t state, next_state;
  logic [IW-1:0] idx;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0] seed_q, lfsr;
  logic aw_ok, w_ok, aw_hs, w_hs, b_hs, r_hs, last, accept, err;
  assign last   = idx == IW'(NUM_WORDS - 1);
  assign accept = start && (state == IDLE || state == DONE);
  assign aw_hs  = m_axil_awvalid && m_axil_awready;
  assign w_hs   = m_axil_wvalid && m_axil_wready;
  assign b_hs   = m_axil_bvalid && m_axil_bready;
  assign r_hs   = m_axil_rvalid && m_axil_rready;
  assign err    = (b_hs && m_axil_bresp != AXIL_RESP_OKAY) ||
                  (r_hs && (m_axil_rresp != AXIL_RESP_OKAY || m_axil_rdata != lfsr));
  assign m_axil_awvalid = state == WR_REQ && !aw_ok;
  assign m_axil_wvalid  = state == WR_REQ && !w_ok;
  assign m_axil_bready  = state == WR_RESP;
  assign m_axil_arvalid = state == RD_REQ;
  assign m_axil_rready  = state == RD_RESP;
  assign m_axil_awaddr  = addr;
  assign m_axil_araddr  = addr;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_wstrb   = '1;
  assign m_axil_wdata   = lfsr;
  assign busy = !(state == IDLE || state == DONE);
  assign done = state == DONE;
  assign pass = done && err_count == '0;
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: next_state = accept ? WR_REQ : state;
      WR_REQ:     next_state = ((aw_ok || aw_hs) && (w_ok || w_hs)) ? WR_RESP : WR_REQ;
      WR_RESP:    next_state = m_axil_bvalid ? (last ? RD_REQ : WR_REQ) : WR_RESP;
      RD_REQ:     next_state = m_axil_arready ? RD_RESP : RD_REQ;
      RD_RESP:    next_state = m_axil_rvalid ? (last ? DONE : RD_REQ) : RD_RESP;
      default:    next_state = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= next_state;
  // aw and w complete independently; each flag remembers its own handshake until both are done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx            <= '0;
      addr           <= BASE_ADDR;
      seed_q         <= '0;
      aw_ok          <= 1'b0;
      w_ok           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      aw_ok <= state == WR_REQ && next_state == WR_REQ && (aw_ok || aw_hs);
      w_ok  <= state == WR_REQ && next_state == WR_REQ && (w_ok || w_hs);
      if (accept) begin
        seed_q         <= seed;
        err_count      <= '0;
        first_err_addr <= '0;
      end else if (err) begin
        if (err_count == '0) first_err_addr <= addr;
        if (!(&err_count)) err_count <= err_count + ERR_CNT_WIDTH'(1);
      end
      if (accept || (b_hs && last)) begin
        idx  <= '0;
        addr <= BASE_ADDR;
      end else if (b_hs || r_hs) begin
        idx  <= idx + IW'(1);
        addr <= addr + ADDR_WIDTH'(4);
      end
    end
  end
  // the read phase reloads the stored seed so it replays the written sequence
  axil_lfsr32 u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept || (b_hs && last)),
    .seed    (accept ? seed : seed_q),
    .advance ((b_hs && !last) || r_hs),
    .state   (lfsr)
  );
endmodule

// File: tb/tb_axil_mem_tester.sv
// tb_axil_mem_tester: randomized self-checking bench with AXI-lite slave models and an LFSR pattern reference
module tb_axil_mem_tester;
  localparam int NW  = 16;
  localparam int NW2 = 5;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic start = 0, start2 = 0;
  logic [31:0] seed = 0, seed2 = 0;
  logic busy, done, pass;
  logic [15:0] err_count;
  logic [31:0] first_err_addr;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0] awprot, arprot;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic busy2, done2, pass2;
  logic [1:0] err_count2;
  logic [31:0] first_err_addr2;
  logic [31:0] awaddr2, wdata2, araddr2, rdata2;
  logic [2:0] awprot2, arprot2;
  logic [3:0] wstrb2;
  logic [1:0] bresp2, rresp2;
  logic awvalid2, wvalid2, bvalid2, bready2, arvalid2, rvalid2, rready2;
  int tests = 0, fails = 0;

  axil_mem_tester #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'h0), .NUM_WORDS(NW), .ERR_CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
    .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
    .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
    .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready));

  axil_mem_tester #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'h100), .NUM_WORDS(NW2), .ERR_CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .seed(seed2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err_count2), .first_err_addr(first_err_addr2),
    .m_axil_awaddr(awaddr2), .m_axil_awprot(awprot2), .m_axil_awvalid(awvalid2), .m_axil_awready(1'b1),
    .m_axil_wdata(wdata2), .m_axil_wstrb(wstrb2), .m_axil_wvalid(wvalid2), .m_axil_wready(1'b1),
    .m_axil_bresp(bresp2), .m_axil_bvalid(bvalid2), .m_axil_bready(bready2),
    .m_axil_araddr(araddr2), .m_axil_arprot(arprot2), .m_axil_arvalid(arvalid2), .m_axil_arready(1'b1),
    .m_axil_rdata(rdata2), .m_axil_rresp(rresp2), .m_axil_rvalid(rvalid2), .m_axil_rready(rready2));

  // main slave: memory with configurable aw/w wait states, random ready, bad bresp, bit-flip on one word
  int aw_delay = 0, w_delay = 0, flip_idx = -1;
  bit rand_mode = 0, bresp_err = 0, clr = 0;
  int aw_cnt, w_cnt, aw_hi, w_hi, stab_err;
  logic [31:0] rnd, aw_a, w_d, wa, wd, awaddr_q, wdata_q;
  logic aw_got, w_got, aw_pend_q, w_pend_q;
  logic [31:0] mem [NW];
  int wr_cnt [NW];
  logic [31:0] wr_log[$], wr_addr_log[$];
  int aw_hold[$], w_hold[$];
  assign awready = rand_mode ? rnd[0] : (aw_cnt >= aw_delay);
  assign wready  = rand_mode ? rnd[1] : (w_cnt >= w_delay);
  assign arready = rand_mode ? rnd[2] : 1'b1;
  assign wa = aw_got ? aw_a : awaddr;
  assign wd = w_got ? w_d : wdata;
  always @(posedge clk) begin
    rnd <= $urandom;
    if (clr) begin
      wr_log.delete(); wr_addr_log.delete(); aw_hold.delete(); w_hold.delete();
      stab_err <= 0;
      for (int i = 0; i < NW; i++) wr_cnt[i] <= 0;
    end
    if (!rst_n) begin
      bvalid <= 0; rvalid <= 0; aw_got <= 0; w_got <= 0; aw_cnt <= 0; w_cnt <= 0;
      aw_hi <= 0; w_hi <= 0; aw_pend_q <= 0; w_pend_q <= 0; bresp <= 0; rresp <= 0; rdata <= 0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      if (awvalid) aw_hi <= aw_hi + 1;
      if (wvalid) w_hi <= w_hi + 1;
      if (awvalid && awready) begin aw_got <= 1; aw_a <= awaddr; aw_hold.push_back(aw_hi + 1); aw_hi <= 0; end
      if (wvalid && wready) begin w_got <= 1; w_d <= wdata; w_hold.push_back(w_hi + 1); w_hi <= 0; end
      if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready)) && !bvalid) begin
        mem[wa[5:2]] <= wd;
        wr_cnt[wa[5:2]] <= wr_cnt[wa[5:2]] + 1;
        wr_log.push_back(wd); wr_addr_log.push_back(wa);
        bvalid <= 1; bresp <= bresp_err ? 2'b10 : 2'b00;
        aw_got <= 0; w_got <= 0;
      end else if (bvalid && bready) bvalid <= 0;
      if (arvalid && arready) begin
        rvalid <= 1; rresp <= 0;
        rdata <= mem[araddr[5:2]] ^ ((32'(araddr[5:2]) == flip_idx) ? 32'd1 : 32'd0);
      end else if (rvalid && rready) rvalid <= 0;
      aw_pend_q <= awvalid && !awready; awaddr_q <= awaddr;
      w_pend_q  <= wvalid && !wready;   wdata_q  <= wdata;
      if ((aw_pend_q && (!awvalid || awaddr != awaddr_q)) || (w_pend_q && (!wvalid || wdata != wdata_q)))
        stab_err <= stab_err + 1;
    end
  end

  // second slave: always ready, every read returns 0 (never a valid LFSR state)
  logic [31:0] wr2_log[$];
  always @(posedge clk) begin
    if (clr) wr2_log.delete();
    if (!rst_n) begin
      bvalid2 <= 0; rvalid2 <= 0; bresp2 <= 0; rresp2 <= 0; rdata2 <= 0;
    end else begin
      if (awvalid2 && wvalid2) begin bvalid2 <= 1; wr2_log.push_back(wdata2); end
      else if (bvalid2 && bready2) bvalid2 <= 0;
      if (arvalid2) begin rvalid2 <= 1; rdata2 <= 0; end
      else if (rvalid2 && rready2) rvalid2 <= 0;
    end
  end

  function automatic logic [31:0] pattern(logic [31:0] sd, int i);
    logic [31:0] s = (sd == 0) ? 32'd1 : sd;
    for (int k = 0; k < i; k++) s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    return s;
  endfunction

  task automatic clear_logs();
    clr = 1; @(negedge clk); clr = 0;
  endtask

  task automatic run(input logic [31:0] sd);
    bit ok = 0;
    clear_logs();
    seed = sd; start = 1; @(negedge clk); start = 0;
    for (int c = 0; c < 3000 && !ok; c++) begin @(negedge clk); ok = done; end
    tests++;
    if (!ok) begin fails++; $display("FAIL run_timeout: done=%0b required 1", done); end
  endtask

  task automatic check_pattern(input logic [31:0] sd, input string name);
    int bad = 0;
    for (int i = 0; i < NW; i++)
      if (i >= wr_log.size() || wr_log[i] !== pattern(sd, i) || wr_addr_log[i] !== 32'(i * 4) || wr_cnt[i] != 1) bad++;
    tests++;
    if (bad != 0 || wr_log.size() != NW) begin
      fails++; $display("FAIL %s: %0d bad words of %0d writes, required 0 bad of %0d", name, bad, wr_log.size(), NW);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; repeat (3) @(negedge clk);
    tests++; if ({busy, done, pass} !== 3'b000) begin fails++; $display("FAIL reset_status: %b required 000", {busy, done, pass}); end
    tests++; if (err_count !== 16'd0) begin fails++; $display("FAIL reset_err_count: %0d required 0", err_count); end
    tests++; if (first_err_addr !== 32'd0) begin fails++; $display("FAIL reset_first_err: %h required 0", first_err_addr); end
    tests++; if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin fails++; $display("FAIL reset_handshake: %b required 00000", {awvalid, wvalid, bready, arvalid, rready}); end
    tests++; if ({busy2, done2, err_count2} !== 4'b0) begin fails++; $display("FAIL reset_dut2: %b required 0000", {busy2, done2, err_count2}); end
    rst_n = 1; @(negedge clk);
  endtask

  task automatic test_basic();
    run(32'hACE1);
    tests++; if ({done, pass} !== 2'b11) begin fails++; $display("FAIL basic_pass: done,pass=%b required 11", {done, pass}); end
    tests++; if (err_count !== 16'd0) begin fails++; $display("FAIL basic_err_count: %0d required 0", err_count); end
    check_pattern(32'hACE1, "basic_writes");
    tests++; if ({awprot, wstrb} !== 7'b000_1111) begin fails++; $display("FAIL basic_prot_strb: %b required 0001111", {awprot, wstrb}); end
    tests++; if (stab_err != 0) begin fails++; $display("FAIL basic_stability: %0d required 0", stab_err); end
  endtask

  task automatic test_flip();
    flip_idx = 5; run($urandom); flip_idx = -1;
    tests++; if (err_count !== 16'd1) begin fails++; $display("FAIL flip_err_count: %0d required 1", err_count); end
    tests++; if (first_err_addr !== 32'h14) begin fails++; $display("FAIL flip_first_err: %h required 14", first_err_addr); end
    tests++; if (pass !== 1'b0) begin fails++; $display("FAIL flip_pass: %b required 0", pass); end
    run($urandom);
    tests++; if ({pass, err_count, first_err_addr} !== {1'b1, 16'd0, 32'd0}) begin
      fails++; $display("FAIL restart_clears: pass=%b err=%0d first=%h required 1,0,0", pass, err_count, first_err_addr); end
  endtask

  task automatic test_bresp();
    bresp_err = 1; run($urandom); bresp_err = 0;
    tests++; if (err_count !== 16'd16) begin fails++; $display("FAIL bresp_err_count: %0d required 16", err_count); end
    tests++; if (first_err_addr !== 32'h0) begin fails++; $display("FAIL bresp_first_err: %h required 0", first_err_addr); end
    tests++; if (pass !== 1'b0) begin fails++; $display("FAIL bresp_pass: %b required 0", pass); end
  endtask

  task automatic test_aw_delay();
    int bad_aw = 0, bad_w = 0;
    logic [31:0] sd = $urandom;
    aw_delay = 3; run(sd); aw_delay = 0;
    foreach (aw_hold[i]) if (aw_hold[i] != 4) bad_aw++;
    foreach (w_hold[i]) if (w_hold[i] != 1) bad_w++;
    tests++; if (bad_aw != 0 || aw_hold.size() != NW) begin fails++; $display("FAIL awvalid_hold: %0d bad of %0d required 0 of %0d", bad_aw, aw_hold.size(), NW); end
    tests++; if (bad_w != 0 || w_hold.size() != NW) begin fails++; $display("FAIL wvalid_hold: %0d bad of %0d required 0 of %0d", bad_w, w_hold.size(), NW); end
    check_pattern(sd, "delay_writes");
    tests++; if (pass !== 1'b1 || stab_err != 0) begin fails++; $display("FAIL delay_pass: pass=%b stab=%0d required 1,0", pass, stab_err); end
  endtask

  task automatic test_random();
    rand_mode = 1;
    for (int n = 0; n < 4; n++) begin
      logic [31:0] sd = $urandom;
      run(sd);
      check_pattern(sd, "random_writes");
      tests++; if (pass !== 1'b1 || stab_err != 0) begin fails++; $display("FAIL random_pass: seed=%h pass=%b stab=%0d required 1,0", sd, pass, stab_err); end
    end
    rand_mode = 0;
  endtask

  task automatic test_seed_zero();
    run(32'h0);
    check_pattern(32'h1, "seed_zero_writes");
    tests++; if (pass !== 1'b1) begin fails++; $display("FAIL seed_zero_pass: %b required 1", pass); end
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    seed = $urandom; start = 1; @(negedge clk); start = 0;
    for (int c = 0; c < 500 && !hit; c++) begin @(negedge clk); hit = rready; end
    tests++; if (!hit) begin fails++; $display("FAIL mid_reach_rd_resp: rready=%b required 1", rready); end
    rst_n = 0; @(negedge clk);
    tests++; if ({busy, done, pass, awvalid, wvalid, bready, arvalid, rready} !== 8'b0) begin
      fails++; $display("FAIL mid_reset_ctrl: %b required 00000000", {busy, done, pass, awvalid, wvalid, bready, arvalid, rready}); end
    tests++; if ({err_count, first_err_addr} !== 48'd0) begin fails++; $display("FAIL mid_reset_err: %0d %h required 0 0", err_count, first_err_addr); end
    rst_n = 1; @(negedge clk);
    run($urandom);
    tests++; if (pass !== 1'b1) begin fails++; $display("FAIL mid_rerun_pass: %b required 1", pass); end
  endtask

  task automatic test_saturate();
    bit ok = 0;
    logic [31:0] sa = $urandom;
    clear_logs();
    seed2 = sa; start2 = 1; @(negedge clk); start2 = 0;
    repeat (3) @(negedge clk);
    seed2 = ~sa; start2 = 1; @(negedge clk); start2 = 0;
    for (int c = 0; c < 500 && !ok; c++) begin @(negedge clk); ok = done2; end
    tests++; if (!ok) begin fails++; $display("FAIL sat_timeout: done2=%b required 1", done2); end
    tests++; if (err_count2 !== 2'd3) begin fails++; $display("FAIL sat_err_count: %0d required 3", err_count2); end
    tests++; if (first_err_addr2 !== 32'h100) begin fails++; $display("FAIL sat_first_err: %h required 100", first_err_addr2); end
    tests++; if (pass2 !== 1'b0) begin fails++; $display("FAIL sat_pass: %b required 0", pass2); end
    tests++; if (wr2_log.size() != NW2 || wr2_log[0] !== pattern(sa, 0) || wr2_log[NW2-1] !== pattern(sa, NW2 - 1)) begin
      fails++; $display("FAIL busy_start_ignored: %0d writes first=%h required %0d writes first=%h", wr2_log.size(), wr2_log.size() > 0 ? wr2_log[0] : 32'h0, NW2, pattern(sa, 0)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flip();
    test_bresp();
    test_aw_delay();
    test_random();
    test_seed_zero();
    test_reset_mid();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
